// File: rtl/bootstrap_pkg.sv
// rtl/bootstrap_pkg.sv - shared encodings for the power-on bootstrap loader
package bootstrap_pkg;

  localparam int ADDR_W      = 17;
  localparam int CTRL_ADDR_W = 12;

  // ROM_SEL drives this encoding straight onto the EEPROM select lines
  typedef enum logic [1:0] {
    REGION_SLICE     = 2'd0,
    REGION_LOOKAHEAD = 2'd1,
    REGION_CONTROL   = 2'd2,
    REGION_DONE      = 2'd3
  } region_e;

  typedef enum logic [2:0] {
    ST_SETUP  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_LATCH  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4
  } byte_state_e;

endpackage

// File: rtl/boot_byte_cycle.sv
// rtl/boot_byte_cycle.sv - per-byte SETUP..HOLD sequencer with EEPROM read wait counter
module boot_byte_cycle
  import bootstrap_pkg::*;
#(
  parameter int READ_WAIT = 2
) (
  input  logic CLK,
  input  logic N_RST,
  input  logic START,
  output logic N_OE,
  output logic LATCH_EN,
  output logic WE_STROBE,
  output logic DONE
);

  localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);

  byte_state_e state_q, state_nxt;
  logic [3:0]  wait_q, wait_nxt;
  logic        n_oe_nxt;

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_q <= ST_SETUP;
      wait_q  <= '0;
      N_OE    <= 1'b1;
    end else begin
      state_q <= state_nxt;
      wait_q  <= wait_nxt;
      N_OE    <= n_oe_nxt;
    end
  end

  // Actions decoded in a state take effect on the edge that leaves it
  always_comb begin
    state_nxt = state_q;
    wait_nxt  = wait_q;
    n_oe_nxt  = N_OE;
    case (state_q)
      ST_SETUP: begin
        wait_nxt = '0;
        if (START) begin
          state_nxt = ST_WAIT;
          n_oe_nxt  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) state_nxt = ST_LATCH;
        else                     wait_nxt  = wait_q + 4'd1;
      end
      ST_LATCH: begin
        state_nxt = ST_STROBE;
        n_oe_nxt  = 1'b1;
      end
      ST_STROBE: state_nxt = ST_HOLD;
      ST_HOLD:   state_nxt = ST_SETUP;
      default:   state_nxt = ST_SETUP;
    endcase
  end

  assign LATCH_EN  = (state_q == ST_LATCH);
  assign WE_STROBE = (state_q == ST_STROBE);
  assign DONE      = (state_q == ST_HOLD);

endmodule

// File: rtl/bootstrapper.sv
// rtl/bootstrapper.sv - power-on copy of MLU tables and microcode from boot EEPROMs into SRAM
module bootstrapper
  import bootstrap_pkg::*;
#(
  parameter int SLICE_DEPTH     = 131072,
  parameter int LOOKAHEAD_DEPTH = 65536,
  parameter int CONTROL_DEPTH   = 4096,
  parameter int READ_WAIT       = 2
) (
  input  logic              CLK,
  input  logic              N_RST,
  input  logic [7:0]        ROM_DATA,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic [1:0]        ROM_SEL,
  output logic              ROM_N_OE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [7:0]        DATA,
  output logic              MLU_SLICE_N_WE,
  output logic              MLU_LOOKAHEAD_N_WE,
  output logic              CONTROL_N_WE,
  output logic              N_BOOTED
);

  localparam logic [ADDR_W-1:0]      SLICE_LAST     = ADDR_W'(SLICE_DEPTH - 1);
  localparam logic [ADDR_W-1:0]      LOOKAHEAD_LAST = ADDR_W'(LOOKAHEAD_DEPTH - 1);
  localparam logic [CTRL_ADDR_W-1:0] CONTROL_LAST   = CTRL_ADDR_W'(CONTROL_DEPTH - 1);

  region_e           region_q, region_nxt;
  logic [ADDR_W-1:0] count_q, count_nxt, count_last;
  logic              latch_en, we_strobe, byte_done, copying;

  assign copying = (region_q != REGION_DONE);

  boot_byte_cycle #(
    .READ_WAIT (READ_WAIT)
  ) u_byte_cycle (
    .CLK       (CLK),
    .N_RST     (N_RST),
    .START     (copying),
    .N_OE      (ROM_N_OE),
    .LATCH_EN  (latch_en),
    .WE_STROBE (we_strobe),
    .DONE      (byte_done)
  );

  always_comb begin
    count_last = '0;
    case (region_q)
      REGION_SLICE:     count_last = SLICE_LAST;
      REGION_LOOKAHEAD: count_last = LOOKAHEAD_LAST;
      REGION_CONTROL:   count_last = {{(ADDR_W - CTRL_ADDR_W){1'b0}}, CONTROL_LAST};
      default:          count_last = '0;
    endcase
  end

  always_comb begin
    region_nxt = region_q;
    count_nxt  = count_q;
    if (byte_done) begin
      if (count_q == count_last) begin
        count_nxt  = '0;
        region_nxt = region_e'(region_q + 2'd1);
      end else begin
        count_nxt  = count_q + 17'd1;
      end
    end
  end

  // ADDR trails the counter by a cycle, so it only moves at the end of SETUP,
  // well clear of the strobe issued in STROBE and released in HOLD
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      region_q           <= REGION_SLICE;
      count_q            <= '0;
      ROM_ADDR           <= '0;
      ROM_SEL            <= 2'd0;
      ADDR               <= '0;
      DATA               <= '0;
      MLU_SLICE_N_WE     <= 1'b1;
      MLU_LOOKAHEAD_N_WE <= 1'b1;
      CONTROL_N_WE       <= 1'b1;
      N_BOOTED           <= 1'b1;
    end else begin
      region_q           <= region_nxt;
      count_q            <= count_nxt;
      ROM_SEL            <= region_nxt;
      N_BOOTED           <= (region_nxt != REGION_DONE);
      if (copying) begin
        ROM_ADDR <= count_q;
        ADDR     <= count_q;
      end
      if (latch_en) DATA <= ROM_DATA;
      MLU_SLICE_N_WE     <= !(we_strobe && region_q == REGION_SLICE);
      MLU_LOOKAHEAD_N_WE <= !(we_strobe && region_q == REGION_LOOKAHEAD);
      CONTROL_N_WE       <= !(we_strobe && region_q == REGION_CONTROL);
    end
  end

endmodule

// File: doc/bootstrapper.md
Name: bootstrapper

Overview:
- Power-on loader. Copies microcode and MLU lookup tables from boot EEPROMs into the KPU's SRAMs.
- Drives the bootstrap write interface consumed by mlu and control_logic: BOOTSTRAP_DATA, BOOTSTRAP_ADDR, the three N_WE strobes and N_BOOTED.
- Walks three regions in fixed order: MLU slice, MLU lookahead, control. It then releases N_BOOTED and goes idle until the next reset.

Parameters:
- SLICE_DEPTH, 131072: bytes copied to MLU slice SRAM. Power of two, at most 2^17.
- LOOKAHEAD_DEPTH, 65536: bytes copied to MLU lookahead SRAM. Power of two, at most 2^17.
- CONTROL_DEPTH, 4096: bytes copied to microcode SRAM. Power of two, at most 2^12.
- READ_WAIT, 2: clock cycles between asserting ROM_N_OE and sampling ROM_DATA. Range 1..15.

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- N_RST  input  1  asynchronous active-low reset
- ROM_DATA  input  8  byte from the selected EEPROM
- ROM_ADDR  output  17  EEPROM byte address
- ROM_SEL  output  2  EEPROM select: 0 slice, 1 lookahead, 2 control, 3 none
- ROM_N_OE  output  1  EEPROM output enable, active low
- ADDR  output  17  SRAM write address (control SRAM uses [11:0])
- DATA  output  8  SRAM write data
- MLU_SLICE_N_WE  output  1  slice SRAM write strobe, active low
- MLU_LOOKAHEAD_N_WE  output  1  lookahead SRAM write strobe, active low
- CONTROL_N_WE  output  1  microcode SRAM write strobe, active low
- N_BOOTED  output  1  high while booting; low once all regions are copied

Behaviour:
- Reset values (async, while N_RST=0):
  - State SETUP, region SLICE, address counter 0, wait counter 0.
  - ROM_ADDR=0, ROM_SEL=0, ROM_N_OE=1, ADDR=0, DATA=0.
  - All N_WE=1, N_BOOTED=1.
- Per-byte FSM; each state lasts one cycle unless noted:
  - SETUP: ROM_ADDR=ADDR=counter; ROM_SEL=region; ROM_N_OE=0; wait counter cleared.
  - WAIT: ROM_N_OE=0. Stays for READ_WAIT cycles, counted in the wait counter.
  - LATCH: DATA<=ROM_DATA; ROM_N_OE returns to 1 next cycle.
  - STROBE: the N_WE of the current region goes 0; the other two stay 1.
  - HOLD: N_WE back to 1; ADDR and DATA unchanged. This gives setup/hold margin around the strobe.
  - After HOLD: counter increments and the FSM returns to SETUP.
- Throughput: exactly 4+READ_WAIT cycles per byte.
- Region wrap, on leaving HOLD with counter = DEPTH-1:
  - Counter resets to 0.
  - Region advances SLICE -> LOOKAHEAD -> CONTROL -> DONE.
  - There is no gap cycle between regions.
- DONE state:
  - N_BOOTED=0, ROM_SEL=3, ROM_N_OE=1, all N_WE=1.
  - ADDR and DATA hold their last values.
  - DONE is absorbing until reset.
- Exactly one N_WE is low at any time, or none. A strobe never overlaps any ADDR/DATA change.
- Reset mid-copy: immediate return to reset values. The strobe is deasserted asynchronously. The copy restarts from SLICE address 0 on the first rising edge after N_RST deasserts.
- Width rules:
  - Counter is 17 bits.
  - Control region drives ADDR[16:12]=0.
  - Region compare uses each region's DEPTH-1. Counter overflow is never reached.
- Total boot time: (SLICE_DEPTH+LOOKAHEAD_DEPTH+CONTROL_DEPTH)*(4+READ_WAIT) cycles, after which N_BOOTED falls.

Decomposition:
- Package bootstrap_pkg holds:
  - Region encoding: SLICE=0, LOOKAHEAD=1, CONTROL=2, DONE=3. ROM_SEL reuses this encoding.
  - Byte FSM state encoding: SETUP, WAIT, LATCH, STROBE, HOLD.
  - Address width constants 17 and 12.
- One natural sub-module, boot_byte_cycle: the per-byte SETUP..HOLD FSM plus the wait counter.
  - Inputs: CLK, N_RST, START.
  - Outputs: N_OE, LATCH_EN, WE_STROBE, DONE.
  - The top level owns the region and address counters and the strobe demux.

Test Plan:
- Small depths (SLICE=4, LOOKAHEAD=2, CONTROL=2, READ_WAIT=2); ROM model returns {ROM_SEL,ADDR[5:0]}:
  - 8 writes total; slice gets 0x00..0x03, lookahead 0x40..0x41, control 0x80..0x81.
  - N_BOOTED falls at cycle 8*6=48 after reset release.
- Strobe timing, READ_WAIT=1:
  - Each N_WE low pulse is exactly 1 cycle.
  - ADDR/DATA stable from the cycle before each pulse through the cycle after.
  - Pulses are 5 cycles apart; at most one N_WE low at any time.
- Region boundary:
  - Last slice write at ADDR=3 is followed by the first lookahead write at ADDR=0, exactly 4+READ_WAIT cycles later.
  - MLU_SLICE_N_WE never pulses again.
- Reset mid-copy: assert N_RST during STROBE of lookahead byte 1.
  - N_WE goes 1 asynchronously and N_BOOTED=1.
  - After release, the first write is slice ADDR=0 and the full 8-byte sequence repeats.
- DONE stability:
  - 100 cycles after N_BOOTED=0: no N_WE pulses, ROM_N_OE=1, ROM_SEL=3, N_BOOTED stays 0.
- READ_WAIT sampling check, READ_WAIT=3:
  - ROM model drives valid data only from the 3rd WAIT cycle.
  - Captured DATA matches the expected bytes, and the byte period is 7 cycles.
